// File: rtl/ifte_demux.sv
// Two-way stream demultiplexer: each accepted word is queued on the "then" (t)
// or "else" (e) branch FIFO, chosen by its select bit.
module ifte_demux #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 2
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             i,
  input  logic [WIDTH-1:0] in_data,
  input  logic             in_valid,
  output logic             in_ready,
  output logic [WIDTH-1:0] t_data,
  output logic             t_valid,
  input  logic             t_ready,
  output logic [WIDTH-1:0] e_data,
  output logic             e_valid,
  input  logic             e_ready
);

  localparam int AW    = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW    = $clog2(DEPTH) + 1;
  localparam int SLOTS = 1 << AW;

  // Branch index 1 is the t FIFO, index 0 is the e FIFO.
  logic [1:0]       push;
  logic [1:0]       pop;
  logic [1:0]       full;
  logic [1:0]       valid;
  logic [1:0]       out_ready;
  logic [WIDTH-1:0] head [2];
  logic             accept;

  function automatic logic [AW-1:0] bump(input logic [AW-1:0] p);
    return (p == AW'(DEPTH - 1)) ? '0 : p + 1'b1;
  endfunction

  // Ready depends only on the select bit and registered fullness, never on a consumer ready.
  assign in_ready  = i ? !full[1] : !full[0];
  assign accept    = in_valid && in_ready;
  assign out_ready = {t_ready, e_ready};

  for (genvar b = 0; b < 2; b++) begin : g_fifo
    logic [WIDTH-1:0] mem [SLOTS];
    logic [AW-1:0]    rd_ptr;
    logic [AW-1:0]    wr_ptr;
    logic [CW-1:0]    count;

    assign push[b]  = accept && ((b == 1) ? i : !i);
    assign pop[b]   = valid[b] && out_ready[b];
    assign full[b]  = (count == CW'(DEPTH));
    assign valid[b] = (count != '0);
    assign head[b]  = mem[rd_ptr];

    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        rd_ptr <= '0;
        wr_ptr <= '0;
        count  <= '0;
      end else begin
        if (push[b]) wr_ptr <= bump(wr_ptr);
        if (pop[b])  rd_ptr <= bump(rd_ptr);
        if (push[b] && !pop[b])      count <= count + 1'b1;
        else if (pop[b] && !push[b]) count <= count - 1'b1;
      end
    end

    // Storage needs no reset: a slot is only read after it has been written.
    always_ff @(posedge clk) begin
      if (push[b]) mem[wr_ptr] <= in_data;
    end
  end

  assign t_data  = head[1];
  assign t_valid = valid[1];
  assign e_data  = head[0];
  assign e_valid = valid[0];

endmodule

// File: doc/ifte_demux.md
# ifte_demux

Stream demultiplexer that steers each accepted input word to one of two output channels, "then" (`t`) or "else" (`e`), according to a per-word select bit. Each branch has its own FIFO, so a stalled branch never blocks data already queued on the other branch. It sits upstream of per-branch consumers in lowered select/`ifte` datapaths.

## Interface
- `WIDTH`, default 8: data width in bits; must be ≥1.
- `DEPTH`, default 2: entries per branch FIFO; a power of two in 1..16.
- `clk  in  1`: the single clock; all state updates on its rising edge.
- `rst_n  in  1`: reset, asynchronous, active-low.
- `i  in  1`: branch select for the current input word; 1 routes to `t`, 0 routes to `e`.
- `in_data  in  WIDTH`: input word.
- `in_valid  in  1`: input word and `i` are valid.
- `in_ready  out  1`: the block accepts the input word this cycle.
- `t_data  out  WIDTH`: head word of the `t` FIFO.
- `t_valid  out  1`: the `t` FIFO is non-empty.
- `t_ready  in  1`: the `t` consumer accepts the word this cycle.
- `e_data  out  WIDTH`: head word of the `e` FIFO.
- `e_valid  out  1`: the `e` FIFO is non-empty.
- `e_ready  in  1`: the `e` consumer accepts the word this cycle.

## Operation
- **Transfer rule.** A transfer occurs on any channel in a cycle where valid && ready is true at the rising edge.
- **Input ready.**
  - `in_ready = i ? !t_full : !e_full`.
  - It is combinational from `i` and registered FIFO state only. There is no path from `t_ready` or `e_ready` to `in_ready`.
- **Input transfer.** On an input transfer, `in_data` is written at the write pointer of the selected FIFO. That FIFO's count increments, unless the same FIFO pops in the same cycle.
- **Output transfer.** On an output transfer on a branch, that FIFO's read pointer advances and its count decrements, unless the same FIFO is pushed in the same cycle.
- **Pointers.** Each FIFO has read and write pointers of width log2(DEPTH), minimum 1 bit, plus a count of width log2(DEPTH)+1. Pointers wrap modulo DEPTH. Count ranges 0..DEPTH.
- **Status.**
  - `full = (count == DEPTH)`.
  - `valid = (count != 0)`.
  - `data = mem[rd_ptr]`.
- **Ordering.** Order is preserved within a branch. No ordering is defined across branches.
- **Data path.** Data is never modified, duplicated or dropped.
- **Input not valid.** When `in_valid` = 0, `i` and `in_data` are don't-care. `in_ready` may toggle with `i`, but FIFO state is unchanged.

## Timing
- **Reset values.** While `rst_n` = 0, and immediately on its assertion:
  - All pointers and counts are 0.
  - `t_valid` = `e_valid` = 0.
  - `in_ready` = 1.
  - `t_data`/`e_data` are undefined; the bench must not check them while valid = 0.
- **Reset mid-operation.** Asserting reset discards all queued words asynchronously. Deassertion is synchronised by the integrator; the first transfer can occur on the first rising edge after deassertion.
- **Latency.** An input accepted at edge N is visible on `X_valid`/`X_data` after edge N. The minimum latency is 1 cycle, with no combinational bypass.
- **Throughput.** One input word per cycle while the selected FIFO is not full. Each branch can pop one word per cycle.
- **Full FIFO.** When the selected FIFO is full, `in_ready` = 0 even if that branch pops in the same cycle. A full FIFO accepts its next word one cycle after it pops.
- **Simultaneous push and pop on one branch.** Both occur and the count is unchanged. With count = 1 and a push and pop in the same cycle, the next head is the pushed word.
- **Empty FIFO.** When a branch is empty, its ready input is ignored and no pop occurs.
- **Concurrent activity.** A push to one branch and pops on both branches can all occur in the same cycle.
- **Wrap-around.** Pointers wrap from DEPTH-1 to 0 without bubbles.
- **Stability.** While `X_valid` = 1 and `X_ready` = 0, `X_data` is held stable.

## Test plan
- **Reset state.** Drive `rst_n` = 0 mid-stream with 2 words queued on `t`. Required: `t_valid` = `e_valid` = 0 asynchronously and `in_ready` = 1. After release, those 2 words never appear.
- **Routing and latency.** DEPTH=2, both readies held 1. Send 0x11 (i=1), 0x22 (i=0), 0x33 (i=1) on consecutive cycles. Required: `t` emits 0x11, 0x33 and `e` emits 0x22, each one cycle after acceptance, with `in_ready` held at 1.
- **Full and isolation.** DEPTH=2, `t_ready` = 0. Send 0xA0 and 0xA1 with i=1; then present i=1 0xA2. Required: `in_ready` = 0. Switch `i` to 0 with 0xB0: it is accepted and `e` emits 0xB0 while `t` stays full.
- **Pop at full.** Continuing from the previous scenario, assert `t_ready` for one cycle while i=1 0xA2 is presented. Required: 0xA0 is popped, 0xA2 is not accepted that cycle, and 0xA2 is accepted the next cycle. `t` then emits 0xA1, 0xA2.
- **Push and pop at count 1.** With 0xC0 queued on `e` and `e_ready` = 1, push i=0 0xC1. Required: 0xC0 is emitted, count stays 1, and the next head is 0xC1.
- **Random stress.** DEPTH=4, 10,000 random words with random `i`, `in_valid`, `t_ready` and `e_ready`. Required: per-branch scoreboard order matches, with no loss or duplication, and the pointers wrap many times.
